// File: rtl/hwpe_stream_fifo_scm_mbist.sv
// ============================================================================
// Module   : hwpe_stream_fifo_scm_mbist
// Purpose  : FIFO storage array wrapper with an on-chip March C- memory BIST
//            engine, a three-way port arbiter (engine > tester > functional)
//            and an optional read-path fault injector.
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            ReadEnable/ReadAddr       - functional read port
//            WriteEnable/Addr/Data     - functional write port
//            ReadData                  - registered read data (all sources)
//            BIST, CSN_T, WEN_T, A_T,
//            D_T, Q_T                  - external tester port (active-low CS/WE)
//            bist_start                - one-cycle pulse starting March C-
//            bist_busy/done/fail       - engine status
//            bist_fail_addr/elem       - location of the first miscompare
//            inj_en/addr/mask          - XOR fault injection on read data
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hwpe_stream_fifo_scm_mbist #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          INJECT_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ReadEnable,
    input  logic [ADDR_WIDTH-1:0] ReadAddr,
    output logic [DATA_WIDTH-1:0] ReadData,

    input  logic                  WriteEnable,
    input  logic [ADDR_WIDTH-1:0] WriteAddr,
    input  logic [DATA_WIDTH-1:0] WriteData,

    input  logic                  BIST,
    input  logic                  CSN_T,
    input  logic                  WEN_T,
    input  logic [ADDR_WIDTH-1:0] A_T,
    input  logic [DATA_WIDTH-1:0] D_T,
    output logic [DATA_WIDTH-1:0] Q_T,

    input  logic                  bist_start,
    output logic                  bist_busy,
    output logic                  bist_done,
    output logic                  bist_fail,
    output logic [ADDR_WIDTH-1:0] bist_fail_addr,
    output logic [2:0]            bist_fail_elem,

    input  logic                  inj_en,
    input  logic [ADDR_WIDTH-1:0] inj_addr,
    input  logic [DATA_WIDTH-1:0] inj_mask
);

    localparam logic [ADDR_WIDTH-1:0] c_ADDR_LAST = '1;
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ZERO = '0;
    localparam logic [DATA_WIDTH-1:0] c_D0        = '0;
    localparam logic [DATA_WIDTH-1:0] c_D1        = '1;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_E0    = 4'd1,
        S_E1    = 4'd2,
        S_E2    = 4'd3,
        S_E3    = 4'd4,
        S_E4    = 4'd5,
        S_E5    = 4'd6,
        S_DRAIN = 4'd7,
        S_DONE  = 4'd8
    } state_t;

    // ------------------------------------------------------------------
    // Engine state
    // ------------------------------------------------------------------
    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [ADDR_WIDTH-1:0]   w_addr_nxt;
    logic                    r_phase;       // 0 = read phase, 1 = compare/write phase
    logic                    w_phase_nxt;
    logic                    r_fail;
    logic [ADDR_WIDTH-1:0]   r_fail_addr;
    logic [2:0]              r_fail_elem;

    // Engine memory requests and compare strobe
    logic                    w_eng_re;
    logic                    w_eng_we;
    logic [DATA_WIDTH-1:0]   w_eng_wdata;
    logic                    w_cmp_en;
    logic [DATA_WIDTH-1:0]   w_cmp_exp;
    logic [ADDR_WIDTH-1:0]   w_cmp_addr;
    logic [2:0]              w_cmp_elem;
    logic                    w_miscmp;
    logic                    w_busy;
    logic                    w_start;

    // Per-element parameters of the read/write elements E1..E4
    logic                    w_el_up;
    logic [DATA_WIDTH-1:0]   w_el_exp;
    logic [DATA_WIDTH-1:0]   w_el_wval;
    logic [2:0]              w_el_code;
    state_t                  w_el_next;
    logic [ADDR_WIDTH-1:0]   w_el_next_addr;   // first address of the next element
    logic [ADDR_WIDTH-1:0]   w_el_end;

    // Arbitrated memory port
    logic                    w_mem_re;
    logic [ADDR_WIDTH-1:0]   w_mem_raddr;
    logic                    w_mem_we;
    logic [ADDR_WIDTH-1:0]   w_mem_waddr;
    logic [DATA_WIDTH-1:0]   w_mem_wdata;
    logic                    w_tst_re;
    logic                    w_tst_we;

    // Storage
    logic [DATA_WIDTH-1:0]   r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [ADDR_WIDTH-1:0]   r_raddr;
    logic [DATA_WIDTH-1:0]   w_inj_mask;

    assign w_busy  = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_start = bist_start && !w_busy;

    always_comb begin
        w_el_up        = 1'b1;
        w_el_exp       = c_D0;
        w_el_wval      = c_D1;
        w_el_code      = 3'd1;
        w_el_next      = S_E2;
        w_el_next_addr = c_ADDR_ZERO;
        case (r_state)
            S_E2: begin
                w_el_exp       = c_D1;
                w_el_wval      = c_D0;
                w_el_code      = 3'd2;
                w_el_next      = S_E3;
                w_el_next_addr = c_ADDR_LAST;
            end
            S_E3: begin
                w_el_up        = 1'b0;
                w_el_code      = 3'd3;
                w_el_next      = S_E4;
                w_el_next_addr = c_ADDR_LAST;
            end
            S_E4: begin
                w_el_up        = 1'b0;
                w_el_exp       = c_D1;
                w_el_wval      = c_D0;
                w_el_code      = 3'd4;
                w_el_next      = S_E5;
                w_el_next_addr = c_ADDR_ZERO;
            end
            default: ;
        endcase
        w_el_end = w_el_up ? c_ADDR_LAST : c_ADDR_ZERO;
    end

    // ------------------------------------------------------------------
    // Next-state and engine requests
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_phase_nxt = r_phase;
        w_eng_re    = 1'b0;
        w_eng_we    = 1'b0;
        w_eng_wdata = c_D0;
        w_cmp_en    = 1'b0;
        w_cmp_exp   = c_D0;
        w_cmp_addr  = r_addr;
        w_cmp_elem  = 3'd0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bist_start) begin
                    w_state_nxt = S_E0;
                    w_addr_nxt  = c_ADDR_ZERO;
                    w_phase_nxt = 1'b0;
                end
            end
            S_E0: begin
                w_eng_we    = 1'b1;
                w_eng_wdata = c_D0;
                w_addr_nxt  = r_addr + ADDR_WIDTH'(1);   // wraps to 0 for E1
                if (r_addr == c_ADDR_LAST) begin
                    w_state_nxt = S_E1;
                end
            end
            S_E1, S_E2, S_E3, S_E4: begin
                if (!r_phase) begin
                    w_eng_re    = 1'b1;
                    w_phase_nxt = 1'b1;
                end else begin
                    // ReadData now holds the word read in the previous phase;
                    // the write lands after the read so ordering is safe.
                    w_cmp_en    = 1'b1;
                    w_cmp_exp   = w_el_exp;
                    w_cmp_elem  = w_el_code;
                    w_eng_we    = 1'b1;
                    w_eng_wdata = w_el_wval;
                    w_phase_nxt = 1'b0;
                    if (r_addr == w_el_end) begin
                        w_state_nxt = w_el_next;
                        w_addr_nxt  = w_el_next_addr;
                    end else begin
                        w_addr_nxt = w_el_up ? r_addr + ADDR_WIDTH'(1)
                                             : r_addr - ADDR_WIDTH'(1);
                    end
                end
            end
            S_E5: begin
                // Streaming reads; each compare checks the previous address.
                w_eng_re   = 1'b1;
                w_cmp_en   = (r_addr != c_ADDR_ZERO);
                w_cmp_addr = r_addr - ADDR_WIDTH'(1);
                w_cmp_elem = 3'd5;
                if (r_addr == c_ADDR_LAST) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_addr_nxt = r_addr + ADDR_WIDTH'(1);
                end
            end
            S_DRAIN: begin
                w_cmp_en    = 1'b1;
                w_cmp_addr  = r_addr;
                w_cmp_elem  = 3'd5;
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_miscmp = w_cmp_en && (ReadData != w_cmp_exp);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= c_ADDR_ZERO;
            r_phase     <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_addr <= c_ADDR_ZERO;
            r_fail_elem <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_phase <= w_phase_nxt;
            if (w_start) begin
                r_fail      <= 1'b0;
                r_fail_addr <= c_ADDR_ZERO;
                r_fail_elem <= 3'd0;
            end else if (w_miscmp) begin
                r_fail <= 1'b1;
                if (!r_fail) begin
                    r_fail_addr <= w_cmp_addr;
                    r_fail_elem <= w_cmp_elem;
                end
            end
        end
    end

    assign bist_busy      = w_busy;
    assign bist_done      = (r_state == S_DONE);
    assign bist_fail      = r_fail;
    assign bist_fail_addr = r_fail_addr;
    assign bist_fail_elem = r_fail_elem;

    // ------------------------------------------------------------------
    // Port arbiter: engine > tester > functional
    // ------------------------------------------------------------------
    assign w_tst_re = !CSN_T &&  WEN_T;
    assign w_tst_we = !CSN_T && !WEN_T;

    always_comb begin
        w_mem_re    = ReadEnable;
        w_mem_raddr = ReadAddr;
        w_mem_we    = WriteEnable;
        w_mem_waddr = WriteAddr;
        w_mem_wdata = WriteData;
        if (w_busy) begin
            w_mem_re    = w_eng_re;
            w_mem_raddr = r_addr;
            w_mem_we    = w_eng_we;
            w_mem_waddr = r_addr;
            w_mem_wdata = w_eng_wdata;
        end else if (BIST) begin
            w_mem_re    = w_tst_re;
            w_mem_raddr = A_T;
            w_mem_we    = w_tst_we;
            w_mem_waddr = A_T;
            w_mem_wdata = D_T;
        end
    end

    // ------------------------------------------------------------------
    // Storage: contents are deliberately not reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // Read register captures pre-write contents, giving read-old-data on a
    // same-address read/write and holding its value between reads.
    always_ff @(posedge clk) begin
        if (w_mem_re) begin
            r_rdata <= r_mem[w_mem_raddr];
            r_raddr <= w_mem_raddr;
        end
    end

    generate
        if (INJECT_EN) begin : g_inject
            assign w_inj_mask = (inj_en && (r_raddr == inj_addr)) ? inj_mask : c_D0;
        end else begin : g_no_inject
            logic w_unused_inj;
            assign w_unused_inj = ^{inj_en, inj_addr, inj_mask, r_raddr};
            assign w_inj_mask   = c_D0;
        end
    endgenerate

    assign ReadData = r_rdata ^ w_inj_mask;
    assign Q_T      = ReadData;

endmodule

`default_nettype wire

// File: tb/tb_hwpe_stream_fifo_scm_mbist.sv
// ============================================================================
// Module   : tb_hwpe_stream_fifo_scm_mbist
// Purpose  : Self-checking bench for hwpe_stream_fifo_scm_mbist
//            (ADDR_WIDTH=3, DATA_WIDTH=8, injection present). Read results
//            and BIST outcomes are queued when stimulus is driven and
//            compared when the design produces them.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hwpe_stream_fifo_scm_mbist;

    localparam int AW = 3;
    localparam int DW = 8;
    localparam int NW = 2**AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          ReadEnable;
    logic [AW-1:0] ReadAddr;
    logic [DW-1:0] ReadData;
    logic          WriteEnable;
    logic [AW-1:0] WriteAddr;
    logic [DW-1:0] WriteData;
    logic          BIST;
    logic          CSN_T;
    logic          WEN_T;
    logic [AW-1:0] A_T;
    logic [DW-1:0] D_T;
    logic [DW-1:0] Q_T;
    logic          bist_start;
    logic          bist_busy;
    logic          bist_done;
    logic          bist_fail;
    logic [AW-1:0] bist_fail_addr;
    logic [2:0]    bist_fail_elem;
    logic          inj_en;
    logic [AW-1:0] inj_addr;
    logic [DW-1:0] inj_mask;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] model [NW];
    logic [DW-1:0] rd_q [$];

    typedef struct packed {
        logic          fail;
        logic [AW-1:0] addr;
        logic [2:0]    elem;
    } bist_exp_t;
    bist_exp_t bist_q [$];

    hwpe_stream_fifo_scm_mbist #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .INJECT_EN  (1'b1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ReadEnable     (ReadEnable),
        .ReadAddr       (ReadAddr),
        .ReadData       (ReadData),
        .WriteEnable    (WriteEnable),
        .WriteAddr      (WriteAddr),
        .WriteData      (WriteData),
        .BIST           (BIST),
        .CSN_T          (CSN_T),
        .WEN_T          (WEN_T),
        .A_T            (A_T),
        .D_T            (D_T),
        .Q_T            (Q_T),
        .bist_start     (bist_start),
        .bist_busy      (bist_busy),
        .bist_done      (bist_done),
        .bist_fail      (bist_fail),
        .bist_fail_addr (bist_fail_addr),
        .bist_fail_elem (bist_fail_elem),
        .inj_en         (inj_en),
        .inj_addr       (inj_addr),
        .inj_mask       (inj_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_read(input string tag, input bit tester);
        logic [DW-1:0] exp;
        @(negedge clk);
        exp = rd_q.pop_front();
        if (tester) check(tag, 32'(Q_T), 32'(exp));
        else        check(tag, 32'(ReadData), 32'(exp));
    endtask

    task automatic func_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        WriteEnable = 1'b1; WriteAddr = a; WriteData = d;
        step();
        WriteEnable = 1'b0;
        model[a] = d;
    endtask

    task automatic func_read(input logic [AW-1:0] a, input string tag);
        ReadEnable = 1'b1; ReadAddr = a;
        rd_q.push_back(model[a]);
        step();
        ReadEnable = 1'b0;
        pop_read(tag, 1'b0);
    endtask

    task automatic tester_read(input logic [AW-1:0] a, input string tag);
        BIST = 1'b1; CSN_T = 1'b0; WEN_T = 1'b1; A_T = a;
        rd_q.push_back(model[a]);
        step();
        CSN_T = 1'b1; BIST = 1'b0;
        pop_read(tag, 1'b1);
    endtask

    task automatic noise_off();
        WriteEnable = 1'b0; CSN_T = 1'b1; WEN_T = 1'b1; BIST = 1'b0;
    endtask

    // Starts a run; cycle 0 is the cycle bist_start is high. Optionally
    // raises injection only while E3 runs (cycles 41..56 for N=8) and/or
    // hammers the functional and tester write ports while busy.
    task automatic run_bist(input string tag, input logic exp_fail,
                            input logic [AW-1:0] exp_addr, input logic [2:0] exp_elem,
                            input bit inj_e3, input bit noise);
        int cyc;
        int first_busy;
        int busy_cnt;
        int done_cyc;
        bist_exp_t e;
        bist_q.push_back('{fail: exp_fail, addr: exp_addr, elem: exp_elem});
        bist_start = 1'b1;
        step();
        bist_start = 1'b0;
        cyc = 1; first_busy = -1; busy_cnt = 0; done_cyc = -1;
        while (done_cyc < 0 && cyc <= 200) begin
            if (inj_e3) inj_en = (cyc >= 41 && cyc <= 56);
            if (noise) begin
                BIST = (cyc % 2 == 1);
                WriteEnable = 1'b1; WriteAddr = 3'd3; WriteData = 8'hFF;
                CSN_T = 1'b0; WEN_T = 1'b0; A_T = 3'd6; D_T = 8'hEE;
            end
            @(negedge clk);
            if (bist_busy === 1'b1) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = cyc;
            end
            if (bist_done === 1'b1) begin
                done_cyc = cyc;
            end else begin
                step();
                cyc++;
            end
        end
        if (noise) noise_off();
        if (inj_e3) inj_en = 1'b0;
        check({tag, "_first_busy"}, 32'(first_busy), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(10*NW + 1));
        check({tag, "_done_cycle"}, 32'(done_cyc), 32'(10*NW + 2));
        e = bist_q.pop_front();
        check({tag, "_fail"}, 32'(bist_fail), 32'(e.fail));
        check({tag, "_fail_addr"}, 32'(bist_fail_addr), 32'(e.addr));
        check({tag, "_fail_elem"}, 32'(bist_fail_elem), 32'(e.elem));
        // March C- ends with every word written to zero.
        for (int a = 0; a < NW; a++) model[a] = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        ReadEnable = 1'b0; ReadAddr = '0;
        WriteEnable = 1'b0; WriteAddr = '0; WriteData = '0;
        BIST = 1'b0; CSN_T = 1'b1; WEN_T = 1'b1; A_T = '0; D_T = '0;
        bist_start = 1'b0;
        inj_en = 1'b0; inj_addr = '0; inj_mask = '0;
        for (int a = 0; a < NW; a++) model[a] = 'x;

        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(bist_busy), 32'd0);
        check("rst_done", 32'(bist_done), 32'd0);
        check("rst_fail", 32'(bist_fail), 32'd0);
        check("rst_fail_addr", 32'(bist_fail_addr), 32'd0);
        check("rst_fail_elem", 32'(bist_fail_elem), 32'd0);

        // Clean run, then all words read zero through the tester port
        run_bist("clean", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
        for (int a = 0; a < NW; a++) tester_read(AW'(a), $sformatf("clean_rd%0d", a));

        // Persistent injection at address 5: first failure in E1
        inj_en = 1'b1; inj_addr = 3'd5; inj_mask = 8'h08;
        run_bist("inj5", 1'b1, 3'd5, 3'd1, 1'b0, 1'b0);
        inj_en = 1'b0;

        // Injection only during E3 at address 2
        inj_addr = 3'd2; inj_mask = 8'h80;
        run_bist("inj_e3", 1'b1, 3'd2, 3'd3, 1'b1, 1'b0);

        // Reset in cycle 40 of a failing run
        inj_en = 1'b1; inj_addr = 3'd5; inj_mask = 8'h08;
        bist_start = 1'b1;
        step();
        bist_start = 1'b0;
        repeat (39) step();
        @(negedge clk);
        check("pre_rst_busy", 32'(bist_busy), 32'd1);
        check("pre_rst_fail", 32'(bist_fail), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        inj_en = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 32'(bist_busy), 32'd0);
        check("mid_rst_done", 32'(bist_done), 32'd0);
        check("mid_rst_fail", 32'(bist_fail), 32'd0);
        check("mid_rst_fail_addr", 32'(bist_fail_addr), 32'd0);
        check("mid_rst_fail_elem", 32'(bist_fail_elem), 32'd0);
        run_bist("after_rst", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);

        // Functional write visible through the tester port
        func_write(3'd7, 8'hA5);
        tester_read(3'd7, "tester_rd7");

        // Writes from other sources are ignored while the engine runs
        run_bist("noisy", 1'b0, 3'd0, 3'd0, 1'b0, 1'b1);
        for (int a = 0; a < NW; a++) tester_read(AW'(a), $sformatf("noisy_rd%0d", a));

        // Same-address read/write returns old data; then new data; then hold
        func_write(3'd4, 8'h11);
        WriteEnable = 1'b1; WriteAddr = 3'd4; WriteData = 8'h3C;
        ReadEnable = 1'b1; ReadAddr = 3'd4;
        rd_q.push_back(model[4]);
        step();
        model[4] = 8'h3C;
        WriteEnable = 1'b0; ReadEnable = 1'b0;
        pop_read("raw_old", 1'b0);
        func_read(3'd4, "raw_new");
        step();
        @(negedge clk);
        check("rd_hold", 32'(ReadData), 32'h3C);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
